// File: rtl/sc_bitstream_src_if.sv
// Handshake and stream signals of the stochastic bitstream source.
// The master side drives the request; the slave side is the source itself.
interface sc_bitstream_src_if #(
    parameter int unsigned W  = 6,
    parameter int unsigned LW = $clog2(W + 1)
) ();
    logic          start;
    logic [W-1:0]  x;
    logic [LW-1:0] len_log2;
    logic          et_stop;
    logic          busy;
    logic          z_valid;
    logic          Z;
    logic          rshift;
    logic [W-1:0]  idx;
    logic          done;
    logic [W:0]    n_bits;

    modport master (
        output start, x, len_log2, et_stop,
        input  busy, z_valid, Z, rshift, idx, done, n_bits
    );

    modport slave (
        input  start, x, len_log2, et_stop,
        output busy, z_valid, Z, rshift, idx, done, n_bits
    );
endinterface

// File: rtl/sc_bitstream_src.sv
// Unipolar stochastic bitstream source: compares the latched operand against a
// bit-reversed counter and emits the matching rshift strobe and final length.
module sc_bitstream_src #(
    parameter int unsigned W  = 6,
    parameter int unsigned LW = $clog2(W + 1)
) (
    input logic              clk,
    input logic              rst_n,
    sc_bitstream_src_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [W:0] One = 1;

    state_e        state_q, state_d;
    logic [W:0]    cnt_q, cnt_d;
    logic [W-1:0]  x_q, x_d;
    logic [LW-1:0] len_q, len_d;
    logic [W:0]    n_bits_q, n_bits_d;
    logic [LW-1:0] len_clamped;
    logic [W:0]    last_cnt;
    logic          last_bit;
    logic          run;

    function automatic logic [W-1:0] bitrev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[i] = v[W-1-i];
        end
        return r;
    endfunction

    assign run         = (state_q == StRun);
    assign len_clamped = (bus.len_log2 > LW'(W)) ? LW'(W) : bus.len_log2;
    // Index of the final bit of a 2^len_q stream.
    assign last_cnt    = (One << len_q) - One;
    assign last_bit    = (cnt_q == last_cnt);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        len_d    = len_q;
        n_bits_d = n_bits_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    x_d     = bus.x;
                    len_d   = len_clamped;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                // The bit presented this cycle counts as emitted even on early stop.
                if (last_bit || bus.et_stop) begin
                    n_bits_d = cnt_q + One;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + One;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            x_q      <= '0;
            len_q    <= '0;
            n_bits_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            len_q    <= len_d;
            n_bits_q <= n_bits_d;
        end
    end

    assign bus.busy    = run;
    assign bus.z_valid = run;
    assign bus.Z       = run && (x_q > bitrev(cnt_q[W-1:0]));
    assign bus.rshift  = run && (cnt_q != '0) && ((cnt_q & (cnt_q - One)) == '0);
    assign bus.idx     = run ? cnt_q[W-1:0] : '0;
    assign bus.done    = (state_q == StDone);
    assign bus.n_bits  = n_bits_q;

endmodule

// File: tb/tb_sc_bitstream_src.sv
// Bench for sc_bitstream_src: scoreboard of per-bit expectations plus a table of
// whole-stream lengths and ones counts, and hand sequences for reset and DONE corners.
module tb_sc_bitstream_src;

    localparam int W = 6;

    typedef struct packed {
        logic [W-1:0] idx;
        logic         rshift;
        logic         z;
    } bit_t;

    typedef struct {
        int x;
        int len;
        int stop_at;
        int exp_n;
        int exp_ones;
    } vec_t;

    logic clk;
    logic rst_n;

    sc_bitstream_src_if #(.W(W)) bus ();

    sc_bitstream_src #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks;
    int          errors;
    bit_t        q[$];
    logic [63:0] zlog;
    logic [63:0] rlog;
    int          rs_cnt;
    vec_t        tbl[7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_model(input int xv, input int lv, input int stop_at);
        int   l;
        int   n;
        int   rev;
        bit_t e;
        l = (lv > W) ? W : lv;
        n = 1 << l;
        if (stop_at >= 0 && stop_at < n) n = stop_at + 1;
        for (int i = 0; i < n; i++) begin
            rev = 0;
            for (int b = 0; b < W; b++) begin
                if (((i >> b) & 1) == 1) rev = rev | (1 << (W - 1 - b));
            end
            e.idx    = W'(i);
            e.rshift = ($countones(i) == 1);
            e.z      = (xv > rev);
            q.push_back(e);
        end
    endtask

    // Starts a stream at a negedge and follows it to the cycle after done.
    task automatic run_stream(input int xv, input int lv, input int stop_at,
                              input int exp_n, input int exp_ones, input string tag);
        int   ones;
        int   cyc;
        bit   finished;
        bit_t e;
        q.delete();
        push_model(xv, lv, stop_at);
        zlog     = '0;
        rlog     = '0;
        rs_cnt   = 0;
        ones     = 0;
        cyc      = 0;
        finished = 1'b0;
        bus.x        = W'(xv);
        bus.len_log2 = 3'(lv);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = ~W'(xv);
        while (!finished && cyc < 300) begin
            if (bus.z_valid) begin
                if (q.size() == 0) begin
                    check({tag, " extra bit"}, 64'(bus.idx), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    check($sformatf("%s bit %0d", tag, e.idx),
                          64'({bus.busy, bus.done, bus.idx, bus.rshift, bus.Z}),
                          64'({1'b1, 1'b0, e.idx, e.rshift, e.z}));
                end
                if (bus.Z) ones++;
                if (bus.rshift) rs_cnt++;
                zlog[bus.idx] = bus.Z;
                rlog[bus.idx] = bus.rshift;
                bus.et_stop = (stop_at >= 0) && (int'(bus.idx) == stop_at);
                @(negedge clk);
            end else begin
                check({tag, " done"}, 64'(bus.done), 64'd1);
                check({tag, " n_bits"}, 64'(bus.n_bits), 64'(exp_n));
                check({tag, " missing bits"}, 64'(q.size()), 64'd0);
                finished = 1'b1;
            end
            cyc++;
        end
        if (!finished) check({tag, " timeout"}, 64'd0, 64'd1);
        bus.et_stop = 1'b0;
        check({tag, " ones"}, 64'(ones), 64'(exp_ones));
        @(negedge clk);
        check({tag, " done one cycle"}, 64'({bus.done, bus.busy}), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0] = '{x: 33, len: 2, stop_at: -1, exp_n: 4,  exp_ones: 3};
        tbl[1] = '{x: 0,  len: 6, stop_at: -1, exp_n: 64, exp_ones: 0};
        tbl[2] = '{x: 17, len: 3, stop_at: -1, exp_n: 8,  exp_ones: 3};
        tbl[3] = '{x: 32, len: 2, stop_at: 3,  exp_n: 4,  exp_ones: 2};
        tbl[4] = '{x: 0,  len: 6, stop_at: 0,  exp_n: 1,  exp_ones: 0};
        tbl[5] = '{x: 5,  len: 0, stop_at: -1, exp_n: 1,  exp_ones: 1};
        tbl[6] = '{x: 40, len: 6, stop_at: 10, exp_n: 11, exp_ones: 8};

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.x        = '0;
        bus.len_log2 = '0;
        bus.et_stop  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset outputs",
              64'({bus.busy, bus.z_valid, bus.Z, bus.rshift, bus.idx, bus.done, bus.n_bits}),
              64'd0);

        run_stream(32, 6, -1, 64, 32, "x32");
        begin
            logic [63:0] exp_z8;
            logic [63:0] exp_rs;
            exp_z8 = 64'h55;
            exp_rs = 64'h0000_0001_0001_0116;
            check("x32 first 8 Z", {56'd0, zlog[7:0]}, exp_z8);
            check("x32 rshift positions", rlog, exp_rs);
            check("x32 rshift count", 64'(rs_cnt), 64'd6);
        end

        // len_log2 = 7 exceeds W and is clamped to a 64-bit stream.
        run_stream(63, 7, -1, 64, 63, "x63");
        check("x63 Z pattern", zlog, 64'h7FFF_FFFF_FFFF_FFFF);

        for (int t = 0; t < 7; t++) begin
            run_stream(tbl[t].x, tbl[t].len, tbl[t].stop_at, tbl[t].exp_n, tbl[t].exp_ones,
                       $sformatf("vec%0d", t));
        end

        bus.et_stop = 1'b1;
        @(negedge clk);
        bus.et_stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("idle et_stop", 64'({bus.busy, bus.z_valid, bus.done, bus.n_bits}), 64'd11);
            @(negedge clk);
        end

        // start during DONE is ignored; held one more cycle it is accepted from IDLE.
        bus.x        = 6'd5;
        bus.len_log2 = 3'd0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("len0 bit", 64'({bus.z_valid, bus.idx, bus.rshift, bus.Z}),
              64'({1'b1, 6'd0, 1'b0, 1'b1}));
        @(negedge clk);
        check("len0 done", 64'({bus.done, bus.z_valid}), 64'b10);
        bus.start = 1'b1;
        @(negedge clk);
        check("start in done ignored", 64'({bus.busy, bus.done}), 64'd0);
        check("len0 n_bits", 64'(bus.n_bits), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        check("start after done", 64'({bus.busy, bus.idx}), 64'({1'b1, 6'd0}));
        @(negedge clk);
        check("second len0 done", 64'(bus.done), 64'd1);
        @(negedge clk);

        bus.x        = 6'd32;
        bus.len_log2 = 3'd6;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40 && bus.idx != 6'd20; i++) @(negedge clk);
        check("reached idx 20", 64'({bus.z_valid, bus.idx, bus.Z}), 64'({1'b1, 6'd20, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("async reset outputs",
              64'({bus.busy, bus.z_valid, bus.Z, bus.rshift, bus.idx, bus.done, bus.n_bits}),
              64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("no done after reset", 64'({bus.busy, bus.done, bus.n_bits}), 64'd0);
        run_stream(32, 2, -1, 4, 2, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
